// File: rtl/job_arb_pkg.sv
// Shared definitions for the job arbiter: FSM state encoding, default
// parameter values and a one-hot to index helper.
package job_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY    = 3'd1,
        ABORT   = 3'd2,
        RECOVER = 3'd3
    } arb_state_t;

    localparam int KILL_HOLD_DEF = 2;
    localparam int TIMEOUT_DEF   = 128;
    localparam int MAX_REQ       = 8;

    // Index of the set bit in a one-hot vector (zero when the vector is empty).
    function automatic logic [2:0] onehot_index(input logic [MAX_REQ-1:0] vec);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/job_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after rr_ptr,
// wrapping modulo N_REQ.
module rr_pick
    import job_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       rr_ptr,
    output logic [2:0]       winner,
    output logic             valid
);

    logic [MAX_REQ-1:0] req_ext;
    logic [3:0]         slot;

    // Scan the requests starting from rr_ptr and keep the first hit.
    always_comb begin
        req_ext = MAX_REQ'(req);
        winner  = '0;
        valid   = 1'b0;
        slot    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            slot = {1'b0, rr_ptr} + 4'(i);
            if (slot >= 4'(N_REQ)) begin
                slot = slot - 4'(N_REQ);
            end
            if (!valid && req_ext[slot[2:0]]) begin
                valid  = 1'b1;
                winner = slot[2:0];
            end
        end
    end

endmodule

// File: rtl/job_arbiter.sv
// Round-robin arbiter sharing one go/kill/done job engine among N_REQ
// requesters. Optional watchdog abort enabled by defining JOB_ARB_TIMEOUT_EN.
module job_arbiter
    import job_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int KILL_HOLD = KILL_HOLD_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] cancel,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] job_done,
    output logic [N_REQ-1:0] job_aborted,
    output logic             eng_go,
    output logic             eng_kill,
    input  logic             eng_done,
`ifdef JOB_ARB_TIMEOUT_EN
    output logic             timeout_flag,
`endif
    output logic             busy
);

    localparam int HOLD_W = $clog2(KILL_HOLD + 1);

    arb_state_t        state_q, state_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  job_done_q, job_done_d;
    logic [N_REQ-1:0]  job_aborted_q, job_aborted_d;
    logic              eng_go_q, eng_go_d;
    logic              eng_kill_q, eng_kill_d;
    logic              busy_q, busy_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [2:0]        pick_idx;
    logic              pick_valid;
    logic [2:0]        owner_idx;
    logic [2:0]        next_ptr;
    logic              owner_cancel;
    logic              timeout_hit;

`ifdef JOB_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              to_cause_q, to_cause_d;
    logic              timeout_flag_q, timeout_flag_d;
`endif

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    // Owner bookkeeping: gnt_q is the owner register; a dropped request counts as cancel.
    always_comb begin
        owner_idx    = onehot_index(MAX_REQ'(gnt_q));
        next_ptr     = (owner_idx == 3'(N_REQ - 1)) ? 3'd0 : owner_idx + 3'd1;
        owner_cancel = (|(cancel & gnt_q)) || !(|(req & gnt_q));
`ifdef JOB_ARB_TIMEOUT_EN
        timeout_hit  = (wd_q == WD_W'(TIMEOUT - 1));
`else
        timeout_hit  = 1'b0;
`endif
    end

    // Next-state and registered-output logic of the launch/abort sequencer.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_d         = gnt_q;
        job_done_d    = '0;
        job_aborted_d = '0;
        eng_go_d      = 1'b0;
        eng_kill_d    = 1'b0;
        hold_d        = hold_q;
`ifdef JOB_ARB_TIMEOUT_EN
        wd_d           = wd_q;
        to_cause_d     = to_cause_q;
        timeout_flag_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    eng_go_d = 1'b1;
                    state_d  = BUSY;
`ifdef JOB_ARB_TIMEOUT_EN
                    wd_d       = '0;
                    to_cause_d = 1'b0;
`endif
                end
            end
            BUSY: begin
                if (eng_done) begin
                    job_done_d = gnt_q;
                    gnt_d      = '0;
                    rr_ptr_d   = next_ptr;
                    state_d    = IDLE;
                end else if (owner_cancel || timeout_hit) begin
                    eng_kill_d = 1'b1;
                    hold_d     = HOLD_W'(KILL_HOLD);
                    state_d    = ABORT;
`ifdef JOB_ARB_TIMEOUT_EN
                    to_cause_d = timeout_hit;
`endif
                end else begin
`ifdef JOB_ARB_TIMEOUT_EN
                    wd_d = wd_q + WD_W'(1);
`endif
                end
            end
            ABORT: begin
                if (hold_q == HOLD_W'(1)) begin
                    state_d = RECOVER;
                end else begin
                    eng_kill_d = 1'b1;
                    hold_d     = hold_q - HOLD_W'(1);
                end
            end
            RECOVER: begin
                job_aborted_d = gnt_q;
                gnt_d         = '0;
                rr_ptr_d      = next_ptr;
                state_d       = IDLE;
`ifdef JOB_ARB_TIMEOUT_EN
                timeout_flag_d = to_cause_q;
`endif
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously with the engine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            gnt_q         <= '0;
            job_done_q    <= '0;
            job_aborted_q <= '0;
            eng_go_q      <= 1'b0;
            eng_kill_q    <= 1'b0;
            busy_q        <= 1'b0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            job_done_q    <= job_done_d;
            job_aborted_q <= job_aborted_d;
            eng_go_q      <= eng_go_d;
            eng_kill_q    <= eng_kill_d;
            busy_q        <= busy_d;
            hold_q        <= hold_d;
        end
    end

`ifdef JOB_ARB_TIMEOUT_EN
    // Watchdog registers: cycle count of the current job and abort cause.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q           <= '0;
            to_cause_q     <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            wd_q           <= wd_d;
            to_cause_q     <= to_cause_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign timeout_flag = timeout_flag_q;
`endif

    assign gnt         = gnt_q;
    assign job_done    = job_done_q;
    assign job_aborted = job_aborted_q;
    assign eng_go      = eng_go_q;
    assign eng_kill    = eng_kill_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_job_arbiter.sv
// Self-checking bench for job_arbiter: table-driven arbitration vectors plus
// hand-written cancel, collision, reset and (optional) watchdog sequences.
module tb_job_arbiter;

    localparam int N_REQ   = 4;
    localparam int ENG_RUN = 102;

    logic             clk;
    logic             reset_n;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] cancel;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] job_done;
    logic [N_REQ-1:0] job_aborted;
    logic             eng_go;
    logic             eng_kill;
    logic             eng_done;
    logic             busy;
`ifdef JOB_ARB_TIMEOUT_EN
    logic             timeout_flag;
`endif

    logic             eng_auto;
    logic             eng_done_force;
    int               eng_cnt;

    int checks;
    int failures;

    typedef struct {
        logic [N_REQ-1:0] req;
        logic [N_REQ-1:0] exp_gnt;
    } vec_t;

    vec_t vecs[10];

    job_arbiter #(.N_REQ(N_REQ), .KILL_HOLD(2), .TIMEOUT(128)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .cancel      (cancel),
        .gnt         (gnt),
        .job_done    (job_done),
        .job_aborted (job_aborted),
        .eng_go      (eng_go),
        .eng_kill    (eng_kill),
        .eng_done    (eng_done),
`ifdef JOB_ARB_TIMEOUT_EN
        .timeout_flag(timeout_flag),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: done pulse ENG_RUN cycles after go, cleared by kill or reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)      eng_cnt <= 0;
        else if (eng_kill) eng_cnt <= 0;
        else if (eng_go)   eng_cnt <= ENG_RUN;
        else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
    end

    assign eng_done = (eng_auto && eng_cnt == 1) || eng_done_force;

    // Hard stop in case a sequence never completes.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 200000ns");
        $fatal(1, "[TB] global time limit reached");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] c);
        req    = r;
        cancel = c;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Request, then expect the registered launch one cycle later.
    task automatic launch(input string name, input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] exp_gnt);
        applyStimulus(r, '0);
        step();
        checkOutput({name, "_go"}, 32'(eng_go), 32'd1);
        checkOutput({name, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    endtask

    // Finish the current job with a forced done pulse and release requests.
    task automatic forceDone(input string name, input logic [N_REQ-1:0] exp_owner);
        eng_done_force = 1'b1;
        step();
        eng_done_force = 1'b0;
        checkOutput({name, "_done"}, 32'(job_done), 32'(exp_owner));
        checkOutput({name, "_gnt_clr"}, 32'(gnt), 32'd0);
        applyStimulus('0, '0);
        step();
        checkOutput({name, "_done_pulse"}, 32'(job_done), 32'd0);
    endtask

    initial begin
        int n;
        int bad;
        checks         = 0;
        failures       = 0;
        eng_auto       = 1'b1;
        eng_done_force = 1'b0;
        applyStimulus('0, '0);

        vecs[0] = '{4'b1111, 4'b0001};
        vecs[1] = '{4'b1111, 4'b0010};
        vecs[2] = '{4'b1111, 4'b0100};
        vecs[3] = '{4'b1111, 4'b1000};
        vecs[4] = '{4'b0010, 4'b0010};
        vecs[5] = '{4'b1010, 4'b1000};
        vecs[6] = '{4'b1010, 4'b0010};
        vecs[7] = '{4'b0100, 4'b0100};
        vecs[8] = '{4'b0011, 4'b0001};
        vecs[9] = '{4'b1000, 4'b1000};

        // Reset values
        reset_n = 1'b0;
        step();
        step();
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_done", 32'(job_done), 32'd0);
        checkOutput("rst_abort", 32'(job_aborted), 32'd0);
        checkOutput("rst_go", 32'(eng_go), 32'd0);
        checkOutput("rst_kill", 32'(eng_kill), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        step();

        // Single job with the real engine latency
        launch("single", 4'b0001, 4'b0001);
        step();
        checkOutput("single_go_pulse", 32'(eng_go), 32'd0);
        n = 1;
        while (job_done == '0 && n < 300) begin
            step();
            n++;
        end
        checkOutput("single_latency", 32'(n), 32'(ENG_RUN + 1));
        checkOutput("single_done", 32'(job_done), 32'b0001);
        checkOutput("single_gnt_clr", 32'(gnt), 32'd0);
        checkOutput("single_busy_clr", 32'(busy), 32'd0);
        applyStimulus('0, '0);
        step();
        checkOutput("single_done_pulse", 32'(job_done), 32'd0);

        // Re-reset so the arbitration table starts at rr_ptr=0
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        // Round-robin arbitration table
        eng_auto = 1'b0;
        for (int i = 0; i < 10; i++) begin
            launch($sformatf("vec%0d", i), vecs[i].req, vecs[i].exp_gnt);
            step();
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
            forceDone($sformatf("vec%0d", i), vecs[i].exp_gnt);
        end

        // Cancel by owner 2 ten cycles after launch
        eng_auto = 1'b1;
        launch("cancel", 4'b0100, 4'b0100);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (eng_kill) bad++;
            step();
        end
        checkOutput("cancel_no_early_kill", 32'(bad), 32'd0);
        applyStimulus(4'b0100, 4'b0100);
        step();
        checkOutput("cancel_kill1", 32'(eng_kill), 32'd1);
        checkOutput("cancel_go1", 32'(eng_go), 32'd0);
        step();
        checkOutput("cancel_kill2", 32'(eng_kill), 32'd1);
        checkOutput("cancel_go2", 32'(eng_go), 32'd0);
        step();
        checkOutput("cancel_recover_kill", 32'(eng_kill), 32'd0);
        checkOutput("cancel_recover_abort", 32'(job_aborted), 32'd0);
        checkOutput("cancel_recover_gnt", 32'(gnt), 32'b0100);
        step();
        checkOutput("cancel_aborted", 32'(job_aborted), 32'b0100);
        checkOutput("cancel_gnt_clr", 32'(gnt), 32'd0);
        checkOutput("cancel_busy_clr", 32'(busy), 32'd0);
        checkOutput("cancel_no_done", 32'(job_done), 32'd0);
`ifdef JOB_ARB_TIMEOUT_EN
        checkOutput("cancel_no_toflag", 32'(timeout_flag), 32'd0);
`endif
        applyStimulus('0, '0);
        step();
        checkOutput("cancel_abort_pulse", 32'(job_aborted), 32'd0);

        // Done and cancel collide: done wins, no kill
        eng_auto = 1'b0;
        launch("simul", 4'b1000, 4'b1000);
        step();
        applyStimulus(4'b1000, 4'b1000);
        eng_done_force = 1'b1;
        step();
        eng_done_force = 1'b0;
        checkOutput("simul_done", 32'(job_done), 32'b1000);
        checkOutput("simul_kill", 32'(eng_kill), 32'd0);
        applyStimulus('0, '0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (eng_kill || job_aborted != '0) bad++;
            step();
        end
        checkOutput("simul_no_abort", 32'(bad), 32'd0);

        // Dropped request acts as cancel; done during ABORT is ignored
        launch("drop", 4'b0001, 4'b0001);
        step();
        applyStimulus('0, '0);
        step();
        checkOutput("drop_kill", 32'(eng_kill), 32'd1);
        eng_done_force = 1'b1;
        step();
        eng_done_force = 1'b0;
        checkOutput("drop_kill2", 32'(eng_kill), 32'd1);
        step();
        checkOutput("drop_ignored_done", 32'(job_done), 32'd0);
        step();
        checkOutput("drop_aborted", 32'(job_aborted), 32'b0001);
        step();

        // Asynchronous reset mid-job, then arbitration restarts from 0
        launch("rstmid", 4'b0010, 4'b0010);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rstmid_gnt", 32'(gnt), 32'd0);
        checkOutput("rstmid_go", 32'(eng_go), 32'd0);
        checkOutput("rstmid_kill", 32'(eng_kill), 32'd0);
        checkOutput("rstmid_busy", 32'(busy), 32'd0);
        applyStimulus('0, '0);
        step();
        reset_n = 1'b1;
        step();
        launch("post_rst", 4'b0101, 4'b0001);
        forceDone("post_rst", 4'b0001);

`ifdef JOB_ARB_TIMEOUT_EN
        // Watchdog abort on an engine that never finishes
        eng_auto = 1'b0;
        launch("wdog", 4'b0010, 4'b0010);
        n = 0;
        while (!eng_kill && n < 300) begin
            step();
            n++;
        end
        checkOutput("wdog_latency", 32'(n), 32'd128);
        step();
        step();
        checkOutput("wdog_recover_flag", 32'(timeout_flag), 32'd0);
        step();
        checkOutput("wdog_aborted", 32'(job_aborted), 32'b0010);
        checkOutput("wdog_flag", 32'(timeout_flag), 32'd1);
        applyStimulus('0, '0);
        step();
        checkOutput("wdog_flag_pulse", 32'(timeout_flag), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Invariants checked every cycle
    always @(negedge clk) begin
        if (reset_n) begin
            if ($countones(gnt) > 1) begin
                failures++;
                $display("[TB] FAIL gnt_onehot: got 0x%0h, required at most one bit", gnt);
            end
            if (eng_go && eng_kill) begin
                failures++;
                $display("[TB] FAIL go_kill_overlap: got go=1 kill=1, required not both");
            end
        end
    end

endmodule
